// File: rtl/audio_clk_pkg.sv
// Shared types for the audio serial-clock generator: framing formats,
// FSM state encodings and the mode-decode helper.
package audio_clk_pkg;

  typedef enum logic [1:0] {
    FMT_I2S = 2'd0,
    FMT_LJ  = 2'd1,
    FMT_TDM = 2'd2
  } audio_fmt_e;

  typedef logic [1:0] clk_state_t;

  localparam clk_state_t ST_IDLE    = 2'd0;
  localparam clk_state_t ST_QUALIFY = 2'd1;
  localparam clk_state_t ST_RUN     = 2'd2;

  // Encoding 3 is reserved and falls through to TDM framing.
  function automatic audio_fmt_e decode_mode(input logic [1:0] mode);
    audio_fmt_e fmt;
    case (mode)
      2'd0:    fmt = FMT_I2S;
      2'd1:    fmt = FMT_LJ;
      default: fmt = FMT_TDM;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/audio_clkgen.sv
// Audio BCLK/LRCLK generator: qualifies PLL lock, then divides refclk into
// bit and frame clocks for I2S, left-justified or TDM framing.
module audio_clkgen
  import audio_clk_pkg::*;
#(
  parameter int MCLK_DIV     = 8,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int LOCK_CYCLES  = 1024
) (
  input  logic                            refclk,
  input  logic                            rst,
  input  logic                            pll_locked,
  input  logic                            enable,
  input  logic [1:0]                      mode,
  output logic                            bclk,
  output logic                            lrclk,
  output logic                            bclk_fall,
  output logic                            bclk_rise,
  output logic                            frame_start,
  output logic [$clog2(NUM_CHANNELS)-1:0] slot,
  output logic [$clog2(SLOT_WIDTH)-1:0]   bit_idx,
  output logic                            running
);

  localparam int DIV_W  = $clog2(MCLK_DIV);
  localparam int BIT_W  = $clog2(SLOT_WIDTH);
  localparam int SLOT_W = $clog2(NUM_CHANNELS);
  localparam int FRAME  = NUM_CHANNELS * SLOT_WIDTH;
  localparam int P_W    = $clog2(FRAME) + 1;
  localparam int QC_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(MCLK_DIV / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CHANNELS - 1);
  localparam logic [QC_W-1:0]   QC_LAST   = QC_W'(LOCK_CYCLES - 1);
  localparam logic [P_W-1:0]    P_HALF    = P_W'(FRAME / 2);
  localparam logic [P_W-1:0]    P_I2S_LO  = P_W'(FRAME / 2 - 1);
  localparam logic [P_W-1:0]    P_I2S_HI  = P_W'(FRAME - 2);
  localparam logic [P_W-1:0]    P_LAST    = P_W'(FRAME - 1);

  if ((MCLK_DIV < 2) || ((MCLK_DIV % 2) != 0)) begin : g_bad_mclk_div
    $error("audio_clkgen: MCLK_DIV must be even and >= 2");
  end
  if (SLOT_WIDTH < 2) begin : g_bad_slot_width
    $error("audio_clkgen: SLOT_WIDTH must be >= 2");
  end
  if ((NUM_CHANNELS < 2) || ((NUM_CHANNELS % 2) != 0)) begin : g_bad_num_channels
    $error("audio_clkgen: NUM_CHANNELS must be even and >= 2");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
    $error("audio_clkgen: LOCK_CYCLES must be >= 1");
  end

  logic lk;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  clk_state_t        state_q, state_d;
  logic [QC_W-1:0]   qcnt_q, qcnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  audio_fmt_e        mode_q, mode_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              bclk_fall_q, bclk_fall_d;
  logic              bclk_rise_q, bclk_rise_d;
  logic              frame_start_q, frame_start_d;
  logic              running_q, running_d;
  logic              run_entry;
  logic              div_wrap;
  logic              bit_wrap;

  function automatic logic lrclk_level(input audio_fmt_e fmt,
                                       input logic [SLOT_W-1:0] s,
                                       input logic [BIT_W-1:0] b);
    logic [P_W-1:0] p;
    logic           lvl;
    p = P_W'(s) * P_W'(SLOT_WIDTH) + P_W'(b);
    case (fmt)
      FMT_LJ:  lvl = (p < P_HALF);
      FMT_I2S: lvl = (p >= P_I2S_LO) && (p <= P_I2S_HI);
      default: lvl = (p == P_LAST);
    endcase
    return lvl;
  endfunction

  // Losing enable or lock always wins over the qualify terminal count.
  always_comb begin
    state_d = state_q;
    qcnt_d  = {QC_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (enable && lk) begin
          state_d = ST_QUALIFY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_QUALIFY: begin
        if (!enable || !lk) begin
          state_d = ST_IDLE;
        end else if (qcnt_q == QC_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_QUALIFY;
          qcnt_d  = qcnt_q + QC_W'(1);
        end
      end
      ST_RUN: begin
        if (!enable || !lk) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run_entry = (state_d == ST_RUN) && (state_q != ST_RUN);
    div_wrap  = (div_cnt_q == DIV_LAST);
    bit_wrap  = (bit_q == BIT_LAST);
    mode_d    = run_entry ? decode_mode(mode) : mode_q;
    if ((state_d != ST_RUN) || run_entry) begin
      div_cnt_d = {DIV_W{1'b0}};
      bit_d     = {BIT_W{1'b0}};
      slot_d    = {SLOT_W{1'b0}};
    end else if (div_wrap) begin
      div_cnt_d = {DIV_W{1'b0}};
      bit_d     = bit_wrap ? {BIT_W{1'b0}} : bit_q + BIT_W'(1);
      if (bit_wrap) begin
        slot_d = (slot_q == SLOT_LAST) ? {SLOT_W{1'b0}} : slot_q + SLOT_W'(1);
      end else begin
        slot_d = slot_q;
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      bit_d     = bit_q;
      slot_d    = slot_q;
    end
  end

  // Outputs are derived from next-state values so they line up with the counters.
  always_comb begin
    running_d     = (state_d == ST_RUN);
    bclk_d        = running_d && (div_cnt_d >= DIV_HALF);
    bclk_fall_d   = running_d && (div_cnt_d == {DIV_W{1'b0}});
    bclk_rise_d   = running_d && (div_cnt_d == DIV_HALF);
    frame_start_d = bclk_fall_d && (bit_d == {BIT_W{1'b0}}) && (slot_d == {SLOT_W{1'b0}});
    lrclk_d       = running_d && lrclk_level(mode_d, slot_d, bit_d);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      qcnt_q        <= {QC_W{1'b0}};
      div_cnt_q     <= {DIV_W{1'b0}};
      bit_q         <= {BIT_W{1'b0}};
      slot_q        <= {SLOT_W{1'b0}};
      mode_q        <= FMT_I2S;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      bclk_fall_q   <= 1'b0;
      bclk_rise_q   <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      qcnt_q        <= qcnt_d;
      div_cnt_q     <= div_cnt_d;
      bit_q         <= bit_d;
      slot_q        <= slot_d;
      mode_q        <= mode_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      bclk_fall_q   <= bclk_fall_d;
      bclk_rise_q   <= bclk_rise_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign bclk_fall   = bclk_fall_q;
  assign bclk_rise   = bclk_rise_q;
  assign frame_start = frame_start_q;
  assign slot        = slot_q;
  assign bit_idx     = bit_q;
  assign running     = running_q;

endmodule

// File: tb/tb_audio_clkgen.sv
// Scoreboard bench for audio_clkgen: per-bit expectations are queued by the
// stimulus and checked by monitors on every bclk_fall; timing is checked inline.
module tb_audio_clkgen;

  typedef struct {
    int p;
    int lr;
    int fs;
    int slot;
    int bt;
  } exp_t;

  logic       refclk;
  logic       rst;
  logic       pll_a, en_a, pll_b, en_b;
  logic [1:0] mode_a, mode_b;

  logic       a_bclk, a_lrclk, a_bclk_fall, a_bclk_rise, a_frame_start, a_running;
  logic [0:0] a_slot;
  logic [4:0] a_bit_idx;
  logic       b_bclk, b_lrclk, b_bclk_fall, b_bclk_rise, b_frame_start, b_running;
  logic [2:0] b_slot;
  logic [3:0] b_bit_idx;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  audio_clkgen #(.MCLK_DIV(8), .SLOT_WIDTH(32), .NUM_CHANNELS(2), .LOCK_CYCLES(1024)) u_dut_a (
    .refclk(refclk), .rst(rst), .pll_locked(pll_a), .enable(en_a), .mode(mode_a),
    .bclk(a_bclk), .lrclk(a_lrclk), .bclk_fall(a_bclk_fall), .bclk_rise(a_bclk_rise),
    .frame_start(a_frame_start), .slot(a_slot), .bit_idx(a_bit_idx), .running(a_running)
  );

  audio_clkgen #(.MCLK_DIV(2), .SLOT_WIDTH(16), .NUM_CHANNELS(8), .LOCK_CYCLES(4)) u_dut_b (
    .refclk(refclk), .rst(rst), .pll_locked(pll_b), .enable(en_b), .mode(mode_b),
    .bclk(b_bclk), .lrclk(b_lrclk), .bclk_fall(b_bclk_fall), .bclk_rise(b_bclk_rise),
    .frame_start(b_frame_start), .slot(b_slot), .bit_idx(b_bit_idx), .running(b_running)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic rec_check(input string nm, input exp_t e, input int lr, input int fs,
                           input int bk, input int sl, input int bt);
    n_chk++;
    if (lr !== e.lr || fs !== e.fs || bk !== 0 || sl !== e.slot || bt !== e.bt) begin
      n_fail++;
      $display("FAIL %s p=%0d: got lrclk=%0d fs=%0d bclk=%0d slot=%0d bit=%0d, expected lrclk=%0d fs=%0d bclk=0 slot=%0d bit=%0d",
               nm, e.p, lr, fs, bk, sl, bt, e.lr, e.fs, e.slot, e.bt);
    end
  endtask

  // Hand-derived per-bit expectations: A is 2x32 (I2S 31..62, LJ 0..31), B is 8x16 TDM (127).
  function automatic void push_frames(input int dut, input int fmt, input int nfr);
    exp_t e;
    for (int f = 0; f < nfr; f++) begin
      for (int p = 0; p < ((dut == 0) ? 64 : 128); p++) begin
        e.p  = p;
        e.fs = (p == 0) ? 1 : 0;
        if (dut == 0) begin
          e.slot = p / 32;
          e.bt   = p % 32;
          if (fmt == 0)      e.lr = (p >= 31 && p <= 62) ? 1 : 0;
          else if (fmt == 1) e.lr = (p <= 31) ? 1 : 0;
          else               e.lr = 0;
          qa.push_back(e);
        end else begin
          e.slot = p / 16;
          e.bt   = p % 16;
          e.lr   = (p == 127) ? 1 : 0;
          qb.push_back(e);
        end
      end
    end
  endfunction

  function automatic int outs_a();
    return int'({a_bclk, a_lrclk, a_bclk_fall, a_bclk_rise, a_frame_start, a_running, a_slot, a_bit_idx});
  endfunction

  function automatic int outs_b();
    return int'({b_bclk, b_lrclk, b_bclk_fall, b_bclk_rise, b_frame_start, b_running, b_slot, b_bit_idx});
  endfunction

  function automatic logic cond(input int sel);
    case (sel)
      0:  return a_running;
      1:  return !a_running;
      2:  return a_frame_start;
      3:  return b_running;
      4:  return a_running && (a_slot == 1'd1) && (a_bit_idx == 5'd31) && a_bclk_rise;
      5:  return a_running && (a_slot == 1'd1) && (a_bit_idx == 5'd5);
      6:  return b_lrclk;
      7:  return a_bclk_rise;
      9:  return !a_lrclk;
      10: return a_lrclk;
      11: return !b_lrclk;
      default: return 1'b0;
    endcase
  endfunction

  task automatic count_until(input int sel, input int limit, output int n);
    n = 0;
    do begin
      @(posedge refclk);
      #1;
      n++;
    end while (!cond(sel) && n < limit);
  endtask

  task automatic wait_cond(input int sel, input int limit, input string nm);
    int n;
    n = 0;
    while (!cond(sel) && n < limit) begin
      @(posedge refclk);
      #1;
      n++;
    end
    check(nm, int'(cond(sel)), 1);
  endtask

  task automatic wait_drain(input int dut, input int limit, input string nm);
    int n;
    n = 0;
    while (((dut == 0) ? qa.size() : qb.size()) > 0 && n < limit) begin
      @(posedge refclk);
      #1;
      n++;
    end
    check(nm, (dut == 0) ? qa.size() : qb.size(), 0);
    if (dut == 0) qa.delete();
    else          qb.delete();
  endtask

  always @(negedge refclk) begin : mon_a
    exp_t e;
    if (a_bclk_fall && qa.size() > 0) begin
      e = qa.pop_front();
      rec_check("frame_a", e, int'(a_lrclk), int'(a_frame_start), int'(a_bclk), int'(a_slot), int'(a_bit_idx));
    end
  end

  always @(negedge refclk) begin : mon_b
    exp_t e;
    if (b_bclk_fall && qb.size() > 0) begin
      e = qb.pop_front();
      rec_check("frame_b", e, int'(b_lrclk), int'(b_frame_start), int'(b_bclk), int'(b_slot), int'(b_bit_idx));
    end
  end

  initial begin
    int n, n2;
    rst = 1'b1; pll_a = 1'b0; en_a = 1'b0; mode_a = 2'd0;
    pll_b = 1'b0; en_b = 1'b0; mode_b = 2'd0;
    repeat (3) @(posedge refclk);
    #1;
    check("reset_outs_a", outs_a(), 0);
    check("reset_outs_b", outs_b(), 0);
    rst = 1'b0; en_a = 1'b1;
    repeat (5) @(posedge refclk);
    #1;
    check("idle_without_lock", int'(a_running), 0);

    // I2S bring-up: two full frames scoreboarded from the first RUN cycle.
    push_frames(0, 0, 2);
    pll_a = 1'b1;
    count_until(0, 1500, n);
    check("lock_to_running", n, 1027);
    check("first_run_fall_fs_bclk", int'({a_bclk_fall, a_frame_start, a_bclk}), 6);
    wait_cond(7, 20, "bclk_rise_seen");
    count_until(7, 20, n);
    check("bclk_period", n, 8);
    wait_cond(10, 600, "lrclk_high_seen");
    count_until(9, 600, n);
    check("i2s_lrclk_high_time", n, 256);
    count_until(10, 600, n2);
    check("lrclk_period", n + n2, 512);
    wait_drain(0, 2000, "drain_i2s");

    // Mode change while running must not alter the framing.
    mode_a = 2'd1;
    wait_cond(4, 1000, "frame_end_a");
    push_frames(0, 0, 1);
    wait_drain(0, 1000, "drain_mode_ignored");

    wait_cond(5, 1000, "mid_frame_a");
    en_a = 1'b0;
    @(posedge refclk);
    #1;
    check("enable_drop_outs", outs_a(), 0);

    // Re-entry latches left-justified.
    push_frames(0, 1, 1);
    @(posedge refclk);
    #1;
    en_a = 1'b1;
    count_until(2, 1500, n);
    check("reenable_to_frame_start", n, 1025);
    check("lj_lrclk_at_frame_start", int'(a_lrclk), 1);
    wait_drain(0, 1000, "drain_lj");

    pll_a = 1'b0;
    count_until(1, 20, n);
    check("lock_loss_latency", n, 3);

    pll_a = 1'b1;
    repeat (300) @(posedge refclk);
    #1;
    check("still_qualifying", int'(a_running), 0);
    pll_a = 1'b0;
    @(posedge refclk);
    #1;
    pll_a = 1'b1;
    count_until(0, 1500, n);
    check("glitch_requalify", n + 1, 1028);

    repeat (100) @(posedge refclk);
    #1;
    check("running_before_rst", int'(a_running), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_outs", outs_a(), 0);
    @(posedge refclk);
    #1;
    rst = 1'b0;
    count_until(0, 1500, n);
    check("rst_requalify", n, 1027);
    en_a = 1'b0;

    // TDM on the 8x16, divide-by-2 instance.
    mode_b = 2'd2; en_b = 1'b1;
    push_frames(1, 2, 1);
    @(posedge refclk);
    #1;
    pll_b = 1'b1;
    count_until(3, 50, n);
    check("tdm_lock_to_running", n, 7);
    wait_cond(6, 400, "tdm_pulse_seen");
    count_until(11, 10, n);
    check("tdm_pulse_width", n, 2);
    check("tdm_fs_after_pulse", int'(b_frame_start), 1);
    wait_drain(1, 400, "drain_tdm");

    en_b = 1'b0;
    @(posedge refclk);
    #1;
    check("tdm_disable_outs", outs_b(), 0);
    mode_b = 2'd3;
    push_frames(1, 2, 1);
    en_b = 1'b1;
    wait_drain(1, 600, "drain_reserved_mode");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_clkgen.md
# audio_clkgen

Parametrised audio serial-clock generator driven by the audio PLL output clock. It qualifies the PLL `locked` indication and divides the master clock into a bit clock (BCLK) and a frame clock (LRCLK/FS). It supports I2S, left-justified and TDM framing for any even channel count. It sits between the audio PLL and the codec serialiser/deserialiser blocks, and provides both the pin-level clocks and single-cycle strobes for same-domain logic.

## Interface
Parameters:
- `MCLK_DIV`, 8: refclk cycles per BCLK period; even, ≥2.
- `SLOT_WIDTH`, 32: BCLK periods per channel slot; ≥2.
- `NUM_CHANNELS`, 2: slots per frame; even, ≥2.
- `LOCK_CYCLES`, 1024: consecutive cycles of synchronised lock required before running; ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `refclk` in 1: master audio clock (PLL output); all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: raw PLL lock, asynchronous to `refclk`.
- `enable` in 1: run request.
- `mode` in 2: 0 = I2S, 1 = left-justified, 2 = TDM; 3 is reserved and behaves as TDM.
- `bclk` out 1: bit clock, registered.
- `lrclk` out 1: frame clock / frame sync, registered.
- `bclk_fall` out 1: one-cycle strobe in the cycle where `bclk` goes low.
- `bclk_rise` out 1: one-cycle strobe in the cycle where `bclk` goes high.
- `frame_start` out 1: one-cycle strobe on `bclk_fall` of bit 0, slot 0.
- `slot` out clog2(NUM_CHANNELS): current slot index.
- `bit_idx` out clog2(SLOT_WIDTH): current bit within slot.
- `running` out 1: high in state RUN.

## Operation
- `pll_locked` passes through a 2-flop synchroniser; its output is `lk`.
- FSM states:
  - IDLE: when `enable`&`lk`, go to QUALIFY and clear `qcnt`.
  - QUALIFY: `qcnt`++ each cycle. If `!enable` or `!lk`, go to IDLE. When `qcnt==LOCK_CYCLES-1`, go to RUN.
  - RUN: if `!enable` or `!lk`, go to IDLE immediately.
- Entering RUN loads `div_cnt=0`, `bit_idx=0`, `slot=0` and latches `mode` into `mode_q`. `mode` changes during RUN are ignored until the next entry.
- In RUN, `div_cnt` counts 0..MCLK_DIV-1 and wraps.
  - `bclk` = 0 for `div_cnt` < MCLK_DIV/2, else 1.
  - `bclk_fall` is asserted when `div_cnt==0`; `bclk_rise` when `div_cnt==MCLK_DIV/2`.
- At each `div_cnt` wrap, `bit_idx` advances and wraps at SLOT_WIDTH-1. When `bit_idx` wraps, `slot` advances and wraps at NUM_CHANNELS-1.
- Let p = slot·SLOT_WIDTH+bit_idx and F = NUM_CHANNELS·SLOT_WIDTH. `lrclk` is then:
  - left-justified: 1 while p < F/2.
  - I2S: 1 while F/2-1 ≤ p ≤ F-2, so the edge leads the half-frame by one bit.
  - TDM: 1 only when p == F-1, a one-bit pulse ahead of frame start.
- Leaving RUN for any reason: in the next cycle all outputs return to their reset values. Counters are cleared; there is no partial-frame completion.
- Reset values: `bclk`, `lrclk`, all strobes, `running` = 0; `slot`, `bit_idx` = 0; FSM in IDLE.

## Timing
- Output registers are updated from the state and counters of the same cycle, so `running` rises in the first RUN cycle. `bclk_fall` and `frame_start` are also asserted in that cycle, with `bclk=0`.
- From `pll_locked` rising (with `enable` held high) to `running`: 2 (sync) + 1 (IDLE→QUALIFY) + LOCK_CYCLES cycles.
- Loss of `pll_locked`: `running` drops 3 cycles after the raw input falls (2 sync + 1 register).
- `rst` mid-frame: all outputs are at reset values asynchronously; restart requires full re-qualification.
- Simultaneous `!enable` and the `qcnt` terminal count: IDLE wins.

## Structure
- Shared package `audio_clk_pkg`: `audio_fmt_e` enum (FMT_I2S, FMT_LJ, FMT_TDM) and FSM state typedef (ST_IDLE, ST_QUALIFY, ST_RUN).
- One sub-module `sync_2ff` (generic 2-flop bit synchroniser) for `pll_locked`.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
- Default params, I2S, lock asserted and held: `running` rises exactly 1027 cycles later. `bclk` period is 8 cycles and `lrclk` period is 512 cycles. `lrclk` rises at p=31 and falls at p=63.
- Left-justified: `lrclk` is high for p=0..31 and low for p=32..63. `frame_start` is coincident with the `lrclk` rise.
- TDM, NUM_CHANNELS=8, SLOT_WIDTH=16, MCLK_DIV=2: `lrclk` is one 2-cycle pulse at p=127, and `frame_start` follows 1 cycle after the pulse ends.
- `pll_locked` glitches low for 1 cycle during QUALIFY: returns to IDLE, and the full LOCK_CYCLES count restarts.
- `enable` dropped mid-frame in RUN: all outputs are 0 and `slot`/`bit_idx` are 0 within 1 cycle. Re-enable yields a fresh `frame_start` after LOCK_CYCLES+1 cycles.
- `rst` pulsed mid-RUN: all outputs are zero asynchronously. `mode` changed during RUN has no effect on `lrclk` until the next RUN entry.
